// File: rtl/encoder_8to3_serial.sv
// Serializing 8-to-3 encoder: captures a request vector, then emits one index per beat.
// Define ENCODER_ZERO_CODE_EN to report an all-zero vector as a single out_zero beat.
module encoder_8to3_serial #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_vec,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_zero,
  output logic       busy
);

`ifdef ENCODER_ZERO_CODE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, ZERO = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] idx;
  logic [7:0] sel_mask;
  logic       one_left;

  // Later matches overwrite earlier ones, so scan direction picks the priority end.
  always_comb begin
    idx = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) idx = 3'(i);
      end
    end
  end

  assign sel_mask = 8'd1 << idx;
  assign one_left = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != 8'd0) begin
            pend_d  = in_vec;
            state_d = DRAIN;
          end else begin
`ifdef ENCODER_ZERO_CODE_EN
            state_d = ZERO;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pend_d = pend_q & ~sel_mask;
          if (one_left) state_d = IDLE;
        end
      end
`ifdef ENCODER_ZERO_CODE_EN
      ZERO: begin
        if (out_ready) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        pend_d  = 8'd0;
      end
    endcase
  end

  // Outputs depend only on registered state, never on the handshake inputs.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign out_code  = (state_q == DRAIN) ? idx : 3'd0;
`ifdef ENCODER_ZERO_CODE_EN
  assign out_zero  = (state_q == ZERO);
  assign out_last  = ((state_q == DRAIN) && one_left) || (state_q == ZERO);
`else
  assign out_zero  = 1'b0;
  assign out_last  = (state_q == DRAIN) && one_left;
`endif

endmodule
